systolic_job_scheduler: RTL and testbench
=========================================

// Module: systolic_job_scheduler
// PURPOSE
//  Shares one systolic_matrix_multiplier between NREQ requesters using round-robin arbitration.
//  For each job it: latches the winner's A/B operands, pulses mm_start, waits for mm_done,
//  latches result_c and returns it tagged with the requester id. A watchdog aborts hung jobs.
//  Sits between the requester fabric and the multiplier. It is the only driver of mm_start/mm_matrix_*.
// PARAMETERS
//  DATA_WIDTH      8     element width (matches multiplier)
//  M,N,P           8,8,8 matrix dims: A is MxN, B is NxP, C is MxP
//  NREQ            4     number of requesters (>=2)
//  TIMEOUT_CYCLES  1024  max cycles in WAIT before abort (>=8)
//  ID_W            $clog2(NREQ) requester id width
// PORTS
//  clk          in   1               rising-edge clock
//  rst          in   1               synchronous reset, ACTIVE-LOW (0 = reset)
//  req_valid    in   NREQ            per-requester job request, held until req_ready
//  req_ready    out  NREQ            one-hot grant pulse, 1 cycle; operands taken this cycle
//  req_a        in   NREQ*M*N*DW     requester i's A at slice [i*M*N*DW +: M*N*DW]
//  req_b        in   NREQ*N*P*DW     requester i's B, same slicing
//  mm_start     out  1               1-cycle start pulse to multiplier
//  mm_matrix_a  out  M*N*DW          registered A, stable from LAUNCH until the next grant
//  mm_matrix_b  out  N*P*DW          registered B, stable from LAUNCH until the next grant
//  mm_done      in   1               multiplier completion (level)
//  mm_result_c  in   M*P*DW          multiplier result, valid while mm_done=1
//  resp_valid   out  1               response available
//  resp_ready   in   1               consumer accepts response
//  resp_id      out  ID_W            id of the requester that owns the response
//  resp_c       out  M*P*DW          latched result (all zero on error)
//  resp_err     out  1               1 = job aborted by watchdog
//  busy         out  1               state != IDLE
// BEHAVIOUR
//  Reset (rst=0 at a clk edge): state=IDLE, rr_ptr=0, req_ready=0, mm_start=0, resp_valid=0,
//   resp_err=0, resp_id=0, resp_c=0, mm_matrix_a/b=0, busy=0, wdog=0, armed=0.
//   Reset mid-job drops the job silently. No response is produced for it.
//  FSM: IDLE -> LAUNCH -> WAIT -> RESP -> IDLE
//   IDLE: if |req_valid, grant = first set bit at or after rr_ptr (wrapping mod NREQ).
//     Same cycle: req_ready[g]=1; latch req_a/req_b slice g into mm_matrix_*; latch id g.
//     Update rr_ptr=(g+1)%NREQ. Go to LAUNCH. If no request: stay, outputs low.
//   LAUNCH: mm_start=1 for exactly this cycle; wdog=0; armed=0; -> WAIT.
//   WAIT: wdog++ each cycle. armed<=1 once mm_done=0 is sampled (rejects stale done of prior job).
//     Completion = armed & mm_done: resp_c<=mm_result_c, resp_err<=0 -> RESP.
//     Completion has priority over timeout on the same cycle.
//     wdog==TIMEOUT_CYCLES-1 without completion: resp_c<=0, resp_err<=1 -> RESP.
//   RESP: resp_valid=1, and resp_id/resp_c/resp_err held stable.
//     resp_valid&resp_ready -> IDLE; resp_valid drops next cycle.
//     No new grant happens while in RESP, so there is at most one job outstanding.
//  Latency, grant to mm_start = 1 cycle. Best case, mm_done to resp_valid = 1 cycle.
//  Grant to the next grant is at least 4 cycles.
//  req_valid deasserted before grant: the request is simply not seen. No state is kept per requester.
//  mm_done outside WAIT is ignored. resp_ready outside RESP is ignored.
//  Widths: wdog is $clog2(TIMEOUT_CYCLES)+1 bits. No arithmetic on data, which passes through unchanged.
// STRUCTURE
//  systolic_pkg: state localparams (S_IDLE, S_LAUNCH, S_WAIT, S_RESP), clog2 helper, and
//   the slice-offset macros for the packed operand buses.
//  Sub-module rr_arbiter #(NREQ): inputs req, ptr, en; outputs one-hot gnt and the encoded id.
//   Purely combinational. rr_ptr lives in the scheduler.
//  Top: FSM, operand/result registers, watchdog counter.
// TESTING (bench pairs scheduler with systolic_matrix_multiplier 8x8, DW=8, NREQ=4)
//  1 Reset: rst=0 for 2 clk, with req_valid=4'b1111.
//    -> req_ready=0, mm_start=0, resp_valid=0, busy=0 during reset.
//    -> First grant after release goes to id 0.
//  2 Single job: req 2 with A=identity, B[k]=k+1.
//    -> req_ready=4'b0100 for 1 cycle; mm_start 1 cycle later.
//    -> resp_id=2, resp_c==B (mod 256), resp_err=0.
//  3 Fairness: req_valid=4'b1111 held, with resp_ready=1 always.
//    -> grant order 0,1,2,3,0,1; no requester is starved.
//  4 Backpressure: resp_ready=0 for 20 cycles after resp_valid.
//    -> resp_* stable, no new req_ready, mm_start=0; accepted on the first resp_ready=1.
//  5 Watchdog: stub multiplier never raises done, TIMEOUT_CYCLES=16.
//    -> resp_valid 16 cycles after WAIT entry, resp_err=1, resp_c=0.
//  6 Stale done: stub holds mm_done=1 across LAUNCH, drops it 1 cycle, then raises it.
//    -> completion only on the re-rise. Also: rst=0 during WAIT -> IDLE, no response emitted.

Source files
------------

// File: rtl/systolic_job_scheduler_pkg.sv
// Shared types and helpers for the systolic job scheduler: FSM state encoding,
// a constant clog2, and the slice-offset helper for the packed operand buses.
package systolic_job_scheduler_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } sched_state_e;

    function automatic int unsigned clog2_f(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned x = v - 1; x > 0; x = x >> 1) begin
            r++;
        end
        return r;
    endfunction

    // Low bit of slot idx in a bus of equal-width slots.
    function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/systolic_job_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after ptr_i,
// wrapping modulo NREQ. The pointer itself is owned by the caller.
module rr_arbiter
    import systolic_job_scheduler_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int ID_W = clog2_f(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [ID_W-1:0] ptr_i,
    input  logic            en_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [ID_W-1:0] id_o
);

    localparam logic [ID_W:0] NREQ_W = (ID_W + 1)'(NREQ);

    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic [ID_W-1:0]   off;
    logic [ID_W:0]     sum;
    logic              found;

    always_comb begin
        dbl   = {req_i, req_i} >> ptr_i;
        rot   = dbl[NREQ-1:0];
        off   = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && rot[i]) begin
                off   = ID_W'(i);
                found = 1'b1;
            end
        end
        sum = {1'b0, ptr_i} + {1'b0, off};
        if (sum >= NREQ_W) begin
            sum = sum - NREQ_W;
        end
        gnt_o = '0;
        id_o  = '0;
        if (en_i && found) begin
            id_o  = sum[ID_W-1:0];
            gnt_o = NREQ'(1) << sum[ID_W-1:0];
        end
    end

endmodule

// File: rtl/systolic_job_scheduler.sv
// Shares one matrix multiplier between NREQ requesters: round-robin grant, operand
// latch, start pulse, completion wait with watchdog, and a tagged response.
//
// state    | meaning
// S_IDLE   | arbitrating; a grant latches operands and id
// S_LAUNCH | mm_start high for one cycle, watchdog cleared
// S_WAIT   | waiting for a fresh mm_done or watchdog expiry
// S_RESP   | response presented until resp_ready
module systolic_job_scheduler
    import systolic_job_scheduler_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int M              = 8,
    parameter int N              = 8,
    parameter int P              = 8,
    parameter int NREQ           = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int ID_W           = clog2_f(NREQ)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NREQ-1:0]                req_valid,
    output logic [NREQ-1:0]                req_ready,
    input  logic [NREQ*M*N*DATA_WIDTH-1:0] req_a,
    input  logic [NREQ*N*P*DATA_WIDTH-1:0] req_b,
    output logic                           mm_start,
    output logic [M*N*DATA_WIDTH-1:0]      mm_matrix_a,
    output logic [N*P*DATA_WIDTH-1:0]      mm_matrix_b,
    input  logic                           mm_done,
    input  logic [M*P*DATA_WIDTH-1:0]      mm_result_c,
    output logic                           resp_valid,
    input  logic                           resp_ready,
    output logic [ID_W-1:0]                resp_id,
    output logic [M*P*DATA_WIDTH-1:0]      resp_c,
    output logic                           resp_err,
    output logic                           busy
);

    localparam int A_W  = M * N * DATA_WIDTH;
    localparam int B_W  = N * P * DATA_WIDTH;
    localparam int C_W  = M * P * DATA_WIDTH;
    localparam int WD_W = clog2_f(TIMEOUT_CYCLES) + 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ID_W-1:0] ID_LAST = ID_W'(NREQ - 1);

    sched_state_e    state_q, state_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [A_W-1:0]  a_q, a_d;
    logic [B_W-1:0]  b_q, b_d;
    logic [C_W-1:0]  c_q, c_d;
    logic            err_q, err_d;
    logic [WD_W-1:0] wdog_q, wdog_d;
    logic            armed_q, armed_d;

    logic [NREQ-1:0] arb_gnt;
    logic [ID_W-1:0] arb_id;
    logic            arb_en;

    // Gated by rst so no grant is visible while reset is being applied.
    assign arb_en = (state_q == S_IDLE) && rst;

    rr_arbiter #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_arb (
        .req_i (req_valid),
        .ptr_i (rr_ptr_q),
        .en_i  (arb_en),
        .gnt_o (arb_gnt),
        .id_o  (arb_id)
    );

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        id_d     = id_q;
        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;
        err_d    = err_q;
        wdog_d   = wdog_q;
        armed_d  = armed_q;
        case (state_q)
            S_IDLE: begin
                if (|arb_gnt) begin
                    for (int unsigned i = 0; i < NREQ; i++) begin
                        if (arb_gnt[i]) begin
                            a_d = req_a[slice_lo(i, A_W) +: A_W];
                            b_d = req_b[slice_lo(i, B_W) +: B_W];
                        end
                    end
                    id_d     = arb_id;
                    rr_ptr_d = (arb_id == ID_LAST) ? '0 : arb_id + ID_W'(1);
                    state_d  = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                wdog_d  = '0;
                armed_d = 1'b0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                wdog_d = wdog_q + WD_W'(1);
                // A done still high from the previous job must drop before it counts.
                if (!mm_done) begin
                    armed_d = 1'b1;
                end
                if (armed_q && mm_done) begin
                    c_d     = mm_result_c;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (wdog_q == WD_LAST) begin
                    c_d     = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            id_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            err_q    <= 1'b0;
            wdog_q   <= '0;
            armed_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            a_q      <= a_d;
            b_q      <= b_d;
            c_q      <= c_d;
            err_q    <= err_d;
            wdog_q   <= wdog_d;
            armed_q  <= armed_d;
        end
    end

    assign req_ready   = arb_gnt;
    assign mm_start    = (state_q == S_LAUNCH);
    assign mm_matrix_a = a_q;
    assign mm_matrix_b = b_q;
    assign resp_valid  = (state_q == S_RESP);
    assign resp_id     = id_q;
    assign resp_c      = c_q;
    assign resp_err    = err_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_systolic_job_scheduler.sv
// Scoreboard bench for systolic_job_scheduler with a behavioural multiplier stub
// that can complete normally, hang, or hold a stale done across launch.
module tb_systolic_job_scheduler;

    localparam int DW    = 8;
    localparam int M     = 8;
    localparam int N     = 8;
    localparam int P     = 8;
    localparam int NREQ  = 4;
    localparam int TO    = 16;
    localparam int LAT   = 5;
    localparam int A_W   = M * N * DW;
    localparam int MODE_NORMAL = 0;
    localparam int MODE_HANG   = 1;
    localparam int MODE_STALE  = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*A_W-1:0]  req_a;
    logic [NREQ*A_W-1:0]  req_b;
    logic                 mm_start;
    logic [A_W-1:0]       mm_matrix_a;
    logic [A_W-1:0]       mm_matrix_b;
    logic                 mm_done;
    logic [A_W-1:0]       mm_result_c;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [1:0]           resp_id;
    logic [A_W-1:0]       resp_c;
    logic                 resp_err;
    logic                 busy;

    always #5 clk = ~clk;

    systolic_job_scheduler #(
        .DATA_WIDTH     (DW),
        .M              (M),
        .N              (N),
        .P              (P),
        .NREQ           (NREQ),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .mm_start    (mm_start),
        .mm_matrix_a (mm_matrix_a),
        .mm_matrix_b (mm_matrix_b),
        .mm_done     (mm_done),
        .mm_result_c (mm_result_c),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_c      (resp_c),
        .resp_err    (resp_err),
        .busy        (busy)
    );

    // Requester i sends A = s*I and B[k] = k+1+off, so C[k] = s*(k+1+off) mod 256.
    int s_tab[4]   = '{3, 5, 1, 7};
    int off_tab[4] = '{40, 80, 0, 120};

    function automatic logic [A_W-1:0] mk_a(input int s);
        logic [A_W-1:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r[(i*8+i)*8 +: 8] = 8'(s);
        return r;
    endfunction

    function automatic logic [A_W-1:0] mk_b(input int off);
        logic [A_W-1:0] r;
        for (int k = 0; k < 64; k++) r[k*8 +: 8] = 8'(k + 1 + off);
        return r;
    endfunction

    function automatic logic [A_W-1:0] exp_c(input int s, input int off);
        logic [A_W-1:0] r;
        for (int k = 0; k < 64; k++) r[k*8 +: 8] = 8'(s * (k + 1 + off));
        return r;
    endfunction

    function automatic logic [A_W-1:0] mat_mul(input logic [A_W-1:0] a, input logic [A_W-1:0] b);
        logic [A_W-1:0] r;
        logic [7:0]     acc;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                acc = '0;
                for (int k = 0; k < 8; k++) acc = acc + a[(i*8+k)*8 +: 8] * b[(k*8+j)*8 +: 8];
                r[(i*8+j)*8 +: 8] = acc;
            end
        end
        return r;
    endfunction

    // Multiplier stub: ph counts cycles since the start pulse.
    int             mode = MODE_NORMAL;
    int             ph = 0;
    logic [A_W-1:0] prod = '0;

    always @(posedge clk) begin
        if (mm_start === 1'b1) begin
            ph   <= 1;
            prod <= mat_mul(mm_matrix_a, mm_matrix_b);
        end else if (ph != 0 && ph < 1000) begin
            ph <= ph + 1;
        end
    end

    always_comb begin
        mm_done     = 1'b0;
        mm_result_c = '0;
        case (mode)
            MODE_NORMAL: begin
                mm_done     = (ph >= LAT);
                mm_result_c = mm_done ? prod : '0;
            end
            MODE_STALE: begin
                mm_done     = (ph != 2);
                mm_result_c = (ph >= 3) ? prod : {64{8'hEE}};
            end
            default: ;
        endcase
    end

    typedef struct {
        logic [1:0]     id;
        logic [A_W-1:0] c;
        logic           err;
        int             lat;
    } exp_t;

    exp_t            exp_q[$];
    logic [3:0]      gnt_q[$];
    exp_t            mon_e;
    int              n_cmp = 0;
    int              n_bad = 0;
    int              cyc = 0;
    int              gcyc = 0;
    int              ngrants = 0;
    logic            mon_en = 1'b0;
    logic            prev_gnt = 1'b0;
    logic            prev_rv = 1'b0;
    logic            prev_hs = 1'b0;
    logic [A_W-1:0]  pend_a = '0;
    logic [A_W-1:0]  pend_b = '0;

    task automatic check(input string name, input logic [A_W-1:0] act, input logic [A_W-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic fail(input string name, input int got, input int req);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got %0d, required %0d", name, got, req);
    endtask

    task automatic push_grant(input int id);
        gnt_q.push_back(4'(1) << id);
    endtask

    task automatic push_resp(input int id, input logic [A_W-1:0] c, input logic err, input int lat);
        exp_t e;
        e.id  = 2'(id);
        e.c   = c;
        e.err = err;
        e.lat = lat;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            cyc++;
            check("mm_start", {511'd0, mm_start}, {511'd0, prev_gnt});
            if (prev_gnt) begin
                check("mm_matrix_a", mm_matrix_a, pend_a);
                check("mm_matrix_b", mm_matrix_b, pend_b);
            end
            if (req_ready != 0) begin
                if (gnt_q.size() == 0) check("unexpected_grant", A_W'(req_ready), '0);
                else check("grant", A_W'(req_ready), A_W'(gnt_q.pop_front()));
                for (int i = 0; i < NREQ; i++) begin
                    if (req_ready[i]) begin
                        pend_a = mk_a(s_tab[i]);
                        pend_b = mk_b(off_tab[i]);
                    end
                end
                gcyc = cyc;
                ngrants++;
            end
            if (prev_hs) check("resp_valid_drop", {511'd0, resp_valid}, '0);
            if (resp_valid) begin
                check("grant_in_resp", A_W'(req_ready), '0);
                if (exp_q.size() == 0) begin
                    check("unexpected_resp", {511'd0, resp_valid}, '0);
                end else begin
                    mon_e = exp_q[0];
                    check("resp_id", A_W'(resp_id), A_W'(mon_e.id));
                    check("resp_c", resp_c, mon_e.c);
                    check("resp_err", {511'd0, resp_err}, {511'd0, mon_e.err});
                    if (!prev_rv) check("resp_latency", A_W'(cyc - gcyc), A_W'(mon_e.lat));
                    if (resp_ready) void'(exp_q.pop_front());
                end
            end
            prev_gnt = (req_ready != 0);
            prev_rv  = resp_valid;
            prev_hs  = resp_valid && resp_ready;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grants(input int n, input int budget);
        int k;
        k = 0;
        while (ngrants < n && k < budget) begin
            step();
            k++;
        end
        if (ngrants < n) fail("timeout_grant", ngrants, n);
    endtask

    task automatic wait_drain(input int budget);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            step();
            k++;
        end
        if (exp_q.size() != 0) begin
            fail("timeout_resp", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic wait_rv(input int budget);
        int k;
        k = 0;
        while (!resp_valid && k < budget) begin
            step();
            k++;
        end
        if (!resp_valid) fail("timeout_resp_valid", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got time %0t, required finish earlier", $time);
        $fatal(1, "bench did not finish");
    end

    initial begin
        rst        = 1'b0;
        req_valid  = 4'b1111;
        resp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*A_W +: A_W] = mk_a(s_tab[i]);
            req_b[i*A_W +: A_W] = mk_b(off_tab[i]);
        end
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Reset held two edges with every requester asking.
        for (int r = 0; r < 2; r++) begin
            if (r > 0) step();
            check("rst_req_ready", A_W'(req_ready), '0);
            check("rst_mm_start", {511'd0, mm_start}, '0);
            check("rst_resp_valid", {511'd0, resp_valid}, '0);
            check("rst_busy", {511'd0, busy}, '0);
            check("rst_resp_err", {511'd0, resp_err}, '0);
            check("rst_resp_id", A_W'(resp_id), '0);
            check("rst_resp_c", resp_c, '0);
            check("rst_mm_matrix_a", mm_matrix_a, '0);
        end

        // Fairness: 0,1,2,3,0,1 with all requesters held.
        for (int g = 0; g < 6; g++) begin
            push_grant(g % 4);
            push_resp(g % 4, exp_c(s_tab[g % 4], off_tab[g % 4]), 1'b0, LAT + 2);
        end
        rst = 1'b1;
        wait_grants(6, 200);
        req_valid = 4'b0000;
        wait_drain(200);

        // Single job from requester 2: identity A, so C equals B.
        push_grant(2);
        push_resp(2, mk_b(0), 1'b0, LAT + 2);
        req_valid = 4'b0100;
        wait_grants(7, 50);
        req_valid = 4'b0000;
        wait_drain(50);

        // Backpressure: response held 20 cycles with other requests pending.
        resp_ready = 1'b0;
        push_grant(3);
        push_resp(3, exp_c(7, 120), 1'b0, LAT + 2);
        req_valid = 4'b1011;
        wait_grants(8, 50);
        wait_rv(50);
        repeat (20) step();
        check("bp_busy", {511'd0, busy}, {511'd0, 1'b1});
        req_valid  = 4'b0000;
        resp_ready = 1'b1;
        wait_drain(5);
        check("bp_idle", {511'd0, busy}, '0);

        // Watchdog: multiplier never finishes.
        mode = MODE_HANG;
        push_grant(1);
        push_resp(1, '0, 1'b1, TO + 2);
        req_valid = 4'b0010;
        wait_grants(9, 50);
        req_valid = 4'b0000;
        wait_drain(60);

        // Stale done held across launch; completion only on the re-rise.
        mode = MODE_STALE;
        push_grant(0);
        push_resp(0, exp_c(3, 40), 1'b0, 5);
        req_valid = 4'b0001;
        wait_grants(10, 50);
        req_valid = 4'b0000;
        wait_drain(40);

        // Reset during WAIT drops the job and the round-robin pointer.
        mode = MODE_HANG;
        push_grant(2);
        req_valid = 4'b0100;
        wait_grants(11, 50);
        req_valid = 4'b0000;
        repeat (4) step();
        check("wait_busy", {511'd0, busy}, {511'd0, 1'b1});
        rst = 1'b0;
        step();
        check("midrst_busy", {511'd0, busy}, '0);
        check("midrst_resp_valid", {511'd0, resp_valid}, '0);
        check("midrst_mm_matrix_a", mm_matrix_a, '0);
        rst = 1'b1;
        repeat (20) step();
        mode = MODE_NORMAL;
        push_grant(0);
        push_resp(0, exp_c(3, 40), 1'b0, LAT + 2);
        req_valid = 4'b1001;
        wait_grants(12, 50);
        req_valid = 4'b0000;
        wait_drain(40);

        check("grants_left", A_W'(gnt_q.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
